// File: rtl/bs_fixed_pkg.sv
// Shared Q-format helpers for the Black-Scholes datapath: phase type, |x| clamp
// and the elaboration-time generator for the half-range normal CDF table.
package bs_fixed_pkg;

  localparam int PHI_DW = 16;
  localparam int PHI_FW = 12;
  localparam int ONE    = 1 << PHI_FW;

  typedef logic signed [PHI_DW-1:0] phi_t;

  localparam string NORM_CDF_HALF_MEM = "norm_cdf_half.mem";

  localparam real SQRT_2PI = 2.5066282746310002;

  // Magnitude of a sign-extended sample, clamped to lim; sat flags the clamp.
  function automatic logic [31:0] abs_sat(input logic signed [31:0] x,
                                          input logic [31:0] lim,
                                          output logic sat);
    logic [31:0] mag;
    mag = x[31] ? 32'(-x) : 32'(x);
    sat = (mag >= lim);
    return sat ? lim : mag;
  endfunction

  // round(Phi(k * 2^step_log2 / 2^fw) * 2^fw), via Phi(x) = 1/2 + pdf(x) * sum x^(2n+1)/(2n+1)!!
  function automatic int phi_table_entry(input int k, input int step_log2, input int fw);
    real x, y, e, term, s, pdf;
    x    = real'(k << step_log2) / real'(1 << fw);
    y    = x * x / 2.0;
    e    = 1.0;
    term = 1.0;
    for (int n = 1; n <= 80; n++) begin
      term = term * y / real'(n);
      e    = e + term;
    end
    pdf  = 1.0 / (SQRT_2PI * e);
    s    = 0.0;
    term = x;
    for (int n = 0; n < 160; n++) begin
      s    = s + term;
      term = term * x * x / real'(2 * n + 3);
    end
    return int'((0.5 + pdf * s) * real'(1 << fw));
  endfunction

endpackage

// File: rtl/norm_cdf_half_rom.sv
// Dual-read synchronous ROM holding Phi(x) for x in [0, XMAX] at a power-of-two step.
// The second read port returns the next table point, saturating at the last entry.
module norm_cdf_half_rom
  import bs_fixed_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int DW        = 16,
  parameter int NPTS      = 320,
  parameter int STEP_LOG2 = 6,
  parameter int FW        = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DW-1:0]     v1,
  output logic [DW-1:0]     v2
);

  logic [DW-1:0]     table_q [0:NPTS];
  logic [ADDR_W-1:0] addr_n;

  for (genvar k = 0; k <= NPTS; k++) begin : g_tab
    localparam logic [DW-1:0] VAL = DW'(phi_table_entry(k, STEP_LOG2, FW));
    assign table_q[k] = VAL;
  end

  assign addr_n = (addr >= ADDR_W'(NPTS)) ? ADDR_W'(NPTS) : addr + 1'b1;

  // NOTE: storage and read registers carry no reset; stage valids in the top
  // decide whether the data is meaningful. Non-blocking assignments keep every
  // register sampling the pre-edge values so stages shift cleanly.
  always_ff @(posedge clk) begin
    if (en) begin
      v1 <= table_q[addr];
      v2 <= table_q[addr_n];
    end
  end

endmodule

// File: rtl/norm_cdf_pipe.sv
// Three-stage normal CDF: clamp/abs, table read, interpolate and reflect.
// One global enable stalls every stage together under output backpressure.
module norm_cdf_pipe
  import bs_fixed_pkg::*;
#(
  parameter int DW        = 16,
  parameter int FW        = 12,
  parameter int XMAX      = 5,
  parameter int STEP_LOG2 = 6,
  parameter int TAG_W     = 8,
  parameter int NPTS      = (XMAX << FW) >> STEP_LOG2,
  parameter int ADDR_W    = $clog2(NPTS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_x,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_phi,
  output logic             out_sat,
  output logic [TAG_W-1:0] out_tag
);

  localparam int                     PW    = DW + STEP_LOG2 + 1;
  localparam logic [31:0]            LIM   = 32'(XMAX << FW);
  localparam logic signed [PW-1:0]   ONE_P = PW'(1 << FW);

  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // S1: sign, clamped magnitude, table address and interpolation fraction
  logic [DW:0] a_c;
  logic        sat_c;

  // NOTE: every always_comb output gets a value before any branch so no latch is inferred.
  always_comb begin
    sat_c = 1'b0;
    a_c   = (DW+1)'(abs_sat(32'($signed(in_x)), LIM, sat_c));
  end

  logic                 s1_valid, s1_sign, s1_sat;
  logic [TAG_W-1:0]     s1_tag;
  logic [ADDR_W-1:0]    s1_addr;
  logic [STEP_LOG2-1:0] s1_frac;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_sat   <= 1'b0;
      s1_tag   <= '0;
      s1_addr  <= '0;
      s1_frac  <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_sign  <= in_x[DW-1];
      s1_sat   <= sat_c;
      s1_tag   <= in_tag;
      s1_addr  <= ADDR_W'(a_c >> STEP_LOG2);
      s1_frac  <= a_c[STEP_LOG2-1:0];
    end
  end

  // S2: registered table read; sideband follows alongside
  logic [DW-1:0]        v1, v2;
  logic                 s2_valid, s2_sign, s2_sat;
  logic [TAG_W-1:0]     s2_tag;
  logic [STEP_LOG2-1:0] s2_frac;

  norm_cdf_half_rom #(
    .ADDR_W   (ADDR_W),
    .DW       (DW),
    .NPTS     (NPTS),
    .STEP_LOG2(STEP_LOG2),
    .FW       (FW)
  ) u_rom (
    .clk (clk),
    .en  (en),
    .addr(s1_addr),
    .v1  (v1),
    .v2  (v2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_sat   <= 1'b0;
      s2_tag   <= '0;
      s2_frac  <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_sat   <= s1_sat;
      s2_tag   <= s1_tag;
      s2_frac  <= s1_frac;
    end
  end

  // S3: linear interpolation, reflection for negative x, clamp to [0, ONE]
  logic signed [DW:0]   diff;
  logic signed [PW-1:0] prod, p, phi_s;
  logic [DW-1:0]        phi_c;

  always_comb begin
    diff  = $signed({1'b0, v2}) - $signed({1'b0, v1});
    prod  = PW'(diff) * PW'($signed({1'b0, s2_frac}));
    p     = PW'($signed({1'b0, v1})) + (prod >>> STEP_LOG2);
    phi_s = s2_sign ? ONE_P - p : p;
    phi_c = phi_s[DW-1:0];
    if (phi_s < 0)          phi_c = '0;
    else if (phi_s > ONE_P) phi_c = ONE_P[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_phi   <= '0;
      out_sat   <= 1'b0;
      out_tag   <= '0;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_phi <= phi_c;
        out_sat <= s2_sat;
        out_tag <= s2_tag;
      end
    end
  end

endmodule

// File: tb/tb_norm_cdf_pipe.sv
// Bench for norm_cdf_pipe: directed vectors, random backpressured stream,
// full-range monotonic sweep and a mid-stream reset.
module tb_norm_cdf_pipe;
  import bs_fixed_pkg::*;

  localparam int DW    = 16;
  localparam int TAG_W = 8;
  localparam int NPTS  = 320;
  localparam int XLIM  = 20480;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_x;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_phi;
  logic             out_sat;
  logic [TAG_W-1:0] out_tag;

  always #5 clk = ~clk;

  norm_cdf_pipe #(
    .DW(DW), .FW(12), .XMAX(5), .STEP_LOG2(6), .TAG_W(TAG_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_phi  (out_phi),
    .out_sat  (out_sat),
    .out_tag  (out_tag)
  );

  int n_checks = 0;
  int n_errors = 0;
  int t_ref [0:NPTS];

  function automatic real pdf(input real t);
    return $exp(-t * t / 2.0) / 2.5066282746310002;
  endfunction

  // Simpson integration of the Gaussian pdf from 0 to |x|
  function automatic real model_phi(input real x);
    real ax, h, s, r;
    ax = (x < 0.0) ? -x : x;
    h  = ax / 200.0;
    s  = pdf(0.0) + pdf(ax);
    for (int i = 1; i < 200; i++) s = s + ((i % 2 == 1) ? 4.0 : 2.0) * pdf(h * real'(i));
    r = 0.5 + s * h / 3.0;
    return (x < 0.0) ? 1.0 - r : r;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_tol(input string name, input int got, input int exp, input int tol);
    n_checks++;
    if (got > exp + tol || got < exp - tol) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, got, exp, tol);
    end
  endtask

  // One isolated sample through an empty pipe; lat counts clocks to out_valid.
  task automatic run_one(input logic [15:0] x, input logic [7:0] tag,
                         output int phi, output int sat, output int tg, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_x     = x;
    in_tag   = tag;
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    phi = int'(out_phi);
    sat = int'(out_sat);
    tg  = int'(out_tag);
  endtask

  typedef struct {
    logic [15:0] x;
    logic [7:0]  tag;
    int          phi;
    int          tol;
    int          sat;
  } vec_t;

  vec_t vecs [13];
  int   res_phi [13];

  int rx [64];
  int q [$];
  int phi, sat, tg, lat, xv, xc, k, ep, ph;
  int sent, got, cyc, prev, mono_bad, tab_bad, first_bad;
  int hold_flag, hold_phi, hold_sat, hold_tag;

  initial begin
    vecs = '{
      '{16'h0000, 8'h11, 2048, 0, 0},
      '{16'h1000, 8'h22, 3446, 1, 0},
      '{16'hF000, 8'h33,  650, 1, 0},
      '{16'h7FFF, 8'h44, 4096, 0, 1},
      '{16'h8000, 8'h55,    0, 0, 1},
      '{16'h5000, 8'h66, 4096, 0, 1},
      '{16'hB000, 8'h77,    0, 0, 1},
      '{16'h4FFF, 8'h88, 4096, 0, 0},
      '{16'hB001, 8'h99,    0, 0, 0},
      '{16'h0001, 8'hAA, 2048, 0, 0},
      '{16'hFFFF, 8'hBB, 2048, 0, 0},
      '{16'h0040, 8'hCC, 2074, 0, 0},
      '{16'hFFC0, 8'hDD, 2022, 0, 0}
    };
    for (int i = 0; i <= NPTS; i++) t_ref[i] = int'(4096.0 * model_phi(real'(i) / 64.0));

    // Reset state
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_phi", int'(out_phi), 0);
    check("rst_out_sat", int'(out_sat), 0);
    check("rst_out_tag", int'(out_tag), 0);
    check("rst_in_ready", int'(in_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 13; i++) begin
      run_one(vecs[i].x, vecs[i].tag, phi, sat, tg, lat);
      res_phi[i] = phi;
      check($sformatf("vec%0d_lat", i), lat, 3);
      check_tol($sformatf("vec%0d_phi", i), phi, vecs[i].phi, vecs[i].tol);
      check($sformatf("vec%0d_sat", i), sat, vecs[i].sat);
      check($sformatf("vec%0d_tag", i), tg, int'(vecs[i].tag));
    end
    check("reflect_sum_1", res_phi[1] + res_phi[2], ONE);

    // Random stream with 50% out_ready
    for (int i = 0; i < 64; i++) rx[i] = int'($urandom_range(49152)) - 24576;
    sent = 0; got = 0; cyc = 0; hold_flag = 0;
    q.delete();
    while (got < 64 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (hold_flag != 0)
        check("stall_hold", (out_valid && int'(out_phi) == hold_phi && int'(out_sat) == hold_sat
                             && int'(out_tag) == hold_tag) ? 1 : 0, 1);
      out_ready = 1'($urandom_range(1));
      in_valid  = (sent < 64);
      in_x      = (sent < 64) ? 16'(rx[sent]) : 16'h0;
      in_tag    = 8'(sent);
      #1;
      hold_flag = (out_valid && !out_ready) ? 1 : 0;
      hold_phi  = int'(out_phi);
      hold_sat  = int'(out_sat);
      hold_tag  = int'(out_tag);
      if (out_valid && out_ready) begin
        xv = (q.size() > 0) ? q.pop_front() : 0;
        xc = (xv > XLIM) ? XLIM : ((xv < -XLIM) ? -XLIM : xv);
        ep = int'(4096.0 * model_phi(real'(xc) / 4096.0));
        check_tol($sformatf("rnd%0d_phi", got), int'(out_phi), ep, 2);
        check($sformatf("rnd%0d_sat", got), int'(out_sat), (xv >= XLIM || xv <= -XLIM) ? 1 : 0);
        check($sformatf("rnd%0d_tag", got), int'(out_tag), got % 256);
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(rx[sent]);
        sent++;
      end
    end
    check("rnd_count", got, 64);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Full sweep: monotonic, table points exact, one result per clock
    sent = 0; got = 0; cyc = 0; prev = -1; mono_bad = 0; tab_bad = 0; first_bad = 0;
    q.delete();
    while (got < 40961 && cyc < 41100) begin
      @(negedge clk);
      cyc++;
      in_valid = (sent < 40961);
      in_x     = 16'(-XLIM + sent);
      in_tag   = 8'(sent);
      #1;
      if (out_valid && out_ready) begin
        xv = (q.size() > 0) ? q.pop_front() : 0;
        ph = int'(out_phi);
        if (ph < prev) mono_bad++;
        prev = ph;
        if (xv % 64 == 0) begin
          k  = ((xv < 0) ? -xv : xv) / 64;
          ep = (xv < 0) ? ONE - t_ref[k] : t_ref[k];
          if (ph != ep) begin
            if (tab_bad == 0) first_bad = xv;
            tab_bad++;
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(-XLIM + sent);
        sent++;
      end
    end
    in_valid = 1'b0;
    check("sweep_count", got, 40961);
    check("sweep_cycles", cyc, 40961 + 3);
    check("sweep_monotonic_violations", mono_bad, 0);
    check($sformatf("sweep_table_points(first x=%0d)", first_bad), tab_bad, 0);

    // Mid-stream reset with three samples in flight
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_x     = 16'(i * 1024);
      in_tag   = 8'(8'hC0 + i);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("inflight_out_valid", int'(out_valid), 1);
    check("stall_in_ready", int'(in_ready), 0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_tag", int'(out_tag), 0);
    repeat (2) @(negedge clk);
    check("midrst_hold_valid", int'(out_valid), 0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);
    run_one(16'h1000, 8'hA5, phi, sat, tg, lat);
    check("post_rst_lat", lat, 3);
    check("post_rst_tag", tg, 8'hA5);
    check_tol("post_rst_phi", phi, 3446, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
